// File: rtl/gmc_pkg.sv
// Shared types and constants for the game mode controller slice.
//   state_t     : handover state (RUN, DRAIN, CLEAR)
//   MODE_TENNIS : mode value selecting the tennis engine
//   MODE_SQUASH : mode value selecting the squash engine
package gmc_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    CLEAR = 2'b10
  } state_t;

  localparam logic MODE_TENNIS = 1'b1;
  localparam logic MODE_SQUASH = 1'b0;

endpackage

// File: rtl/game_mode_controller_if.sv
// Game-side bundle between the mode controller, the two game engines and
// the output mux.
//   t_busy / s_busy   : rally-in-progress flags from the tennis / squash engines
//   t_rst_n / s_rst_n : active-low resets to the tennis / squash engines
//   mode              : 1 = tennis, 0 = squash (output mux select)
//   disp_en           : 0 blanks the LED bar and 7-segment display
//   switching         : high while a handover is in progress
// master = controller side, slave = engines / mux side.
interface game_mode_controller_if;

  logic t_busy;
  logic s_busy;
  logic t_rst_n;
  logic s_rst_n;
  logic mode;
  logic disp_en;
  logic switching;

  modport master (
    input  t_busy, s_busy,
    output t_rst_n, s_rst_n, mode, disp_en, switching
  );

  modport slave (
    output t_busy, s_busy,
    input  t_rst_n, s_rst_n, mode, disp_en, switching
  );

endinterface

// File: rtl/gmc_debounce.sv
// Button conditioner: 2-FF synchronizer, tick-sampled debouncer and a
// single-cycle press pulse.
//   clock, reset : system clock, async active-low reset
//   tick         : sampling strobe
//   btn          : raw asynchronous button
//   press        : one-cycle pulse when the button has been high for
//                  DEBOUNCE_TICKS consecutive tick samples
module gmc_debounce #(
  parameter int DEBOUNCE_TICKS = 8,
  parameter int TW             = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic press
);

  logic          sync1_r;
  logic          sync2_r;
  logic [TW-1:0] cnt_r;
  logic          armed_r;
  logic          press_r;

  // Two-stage synchronizer for the raw button.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive high tick samples; fire once, then wait for a low sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r   <= {TW{1'b0}};
      armed_r <= 1'b1;
      press_r <= 1'b0;
    end else begin
      press_r <= 1'b0;
      if (tick) begin
        if (!sync2_r) begin
          cnt_r   <= {TW{1'b0}};
          armed_r <= 1'b1;
        end else if (armed_r) begin
          if (cnt_r == TW'(DEBOUNCE_TICKS - 1)) begin
            press_r <= 1'b1;
            armed_r <= 1'b0;
            cnt_r   <= {TW{1'b0}};
          end else begin
            cnt_r <= cnt_r + TW'(1);
          end
        end
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/game_mode_controller.sv
// Manages the handover of the shared display between the tennis and squash
// engines: debounced select buttons, optional wait for the running rally to
// finish (DRAIN), then a blanked interval holding the incoming engine in
// reset (CLEAR).
//   clock, reset           : system clock, async active-low reset
//   tick                   : 1 kHz timebase strobe gating all tick counters
//   tennis_btn, squash_btn : raw select buttons
//   bus (master)           : busy inputs, engine resets, mode, disp_en, switching
// Optional feature macro GMC_DRAIN_TIMEOUT_EN: abort DRAIN after
// DRAIN_TIMEOUT ticks even if the running engine is still busy.
module game_mode_controller
  import gmc_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 8,
  parameter int CLEAR_TICKS    = 4,
  parameter int DRAIN_TIMEOUT  = 255,
  parameter int TW             = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          tennis_btn,
  input  logic                          squash_btn,
  game_mode_controller_if.master        bus
);

  // Counters must be able to hold every configured tick count.
  if ((DEBOUNCE_TICKS > (2 ** TW) - 1) || (CLEAR_TICKS > (2 ** TW) - 1) ||
      (DRAIN_TIMEOUT > (2 ** TW) - 1)) begin : g_tw_too_narrow
    $error("game_mode_controller: TW too narrow for configured tick counts");
  end

  state_t        state_r;
  logic          mode_r;
  logic          pend_mode_r;
  logic          t_rst_n_r;
  logic          s_rst_n_r;
  logic          disp_en_r;
  logic          switching_r;
  logic [TW-1:0] clear_cnt_r;

  logic t_press_s;
  logic s_press_s;
  logic req_valid_s;
  logic req_mode_s;
  logic cur_busy_s;
  logic drain_expire_s;

  gmc_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .TW(TW)) u_tennis_db (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .btn   (tennis_btn),
    .press (t_press_s)
  );

  gmc_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .TW(TW)) u_squash_db (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .btn   (squash_btn),
    .press (s_press_s)
  );

  // Tennis wins a same-cycle tie; only the selected game's busy matters.
  assign req_valid_s = t_press_s | s_press_s;
  assign req_mode_s  = t_press_s ? MODE_TENNIS : MODE_SQUASH;
  assign cur_busy_s  = (mode_r == MODE_TENNIS) ? bus.t_busy : bus.s_busy;

`ifdef GMC_DRAIN_TIMEOUT_EN
  logic [TW-1:0] drain_cnt_r;

  // Ticks spent in DRAIN; zero whenever the FSM is elsewhere.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drain_cnt_r <= {TW{1'b0}};
    end else if (state_r != DRAIN) begin
      drain_cnt_r <= {TW{1'b0}};
    end else if (tick) begin
      drain_cnt_r <= drain_cnt_r + TW'(1);
    end else begin
      drain_cnt_r <= drain_cnt_r;
    end
  end

  assign drain_expire_s = tick && (drain_cnt_r == TW'(DRAIN_TIMEOUT - 1));
`else
  assign drain_expire_s = 1'b0;
`endif

  // Handover FSM with registered engine resets and display controls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= RUN;
      mode_r      <= MODE_TENNIS;
      pend_mode_r <= MODE_TENNIS;
      t_rst_n_r   <= 1'b1;
      s_rst_n_r   <= 1'b0;
      disp_en_r   <= 1'b1;
      switching_r <= 1'b0;
      clear_cnt_r <= {TW{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          t_rst_n_r   <= (mode_r == MODE_TENNIS);
          s_rst_n_r   <= (mode_r == MODE_SQUASH);
          disp_en_r   <= 1'b1;
          switching_r <= 1'b0;
          if (req_valid_s && (req_mode_s != mode_r)) begin
            pend_mode_r <= req_mode_s;
            switching_r <= 1'b1;
            if (!cur_busy_s) begin
              state_r     <= CLEAR;
              mode_r      <= req_mode_s;
              clear_cnt_r <= {TW{1'b0}};
              t_rst_n_r   <= 1'b0;
              s_rst_n_r   <= 1'b0;
              disp_en_r   <= 1'b0;
            end else begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Running game keeps going and stays visible while draining.
          if (req_valid_s && (req_mode_s == mode_r)) begin
            state_r     <= RUN;
            switching_r <= 1'b0;
          end else if (!cur_busy_s || drain_expire_s) begin
            state_r     <= CLEAR;
            mode_r      <= pend_mode_r;
            clear_cnt_r <= {TW{1'b0}};
            t_rst_n_r   <= 1'b0;
            s_rst_n_r   <= 1'b0;
            disp_en_r   <= 1'b0;
          end else begin
            state_r <= DRAIN;
          end
        end
        CLEAR: begin
          // mode already holds the incoming game; both engines held in reset.
          t_rst_n_r   <= 1'b0;
          s_rst_n_r   <= 1'b0;
          disp_en_r   <= 1'b0;
          switching_r <= 1'b1;
          if (tick) begin
            if (clear_cnt_r == TW'(CLEAR_TICKS - 1)) begin
              state_r     <= RUN;
              t_rst_n_r   <= (mode_r == MODE_TENNIS);
              s_rst_n_r   <= (mode_r == MODE_SQUASH);
              disp_en_r   <= 1'b1;
              switching_r <= 1'b0;
            end else begin
              clear_cnt_r <= clear_cnt_r + TW'(1);
            end
          end
        end
        default: begin
          state_r     <= RUN;
          mode_r      <= MODE_TENNIS;
          t_rst_n_r   <= 1'b1;
          s_rst_n_r   <= 1'b0;
          disp_en_r   <= 1'b1;
          switching_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mode      = mode_r;
  assign bus.t_rst_n   = t_rst_n_r;
  assign bus.s_rst_n   = s_rst_n_r;
  assign bus.disp_en   = disp_en_r;
  assign bus.switching = switching_r;

endmodule

// File: doc/game_mode_controller.md
Name: game_mode_controller

Overview:
- Sequences the shared LED bar and 7-segment display between the tennis and squash engines. Replaces a bare select flop with a managed handover.
- Debounces the two game-select buttons and lets a running rally finish or time out before switching.
- Holds the incoming game in reset for a clear interval while the display is blanked.
- Sits in the top level between the select buttons, the two game instances and the output mux.

Parameters:
- DEBOUNCE_TICKS, 8: consecutive high tick-samples needed to accept a press.
- CLEAR_TICKS, 4: ticks the incoming game is held in reset with the display blanked.
- DRAIN_TIMEOUT, 255: maximum ticks to wait for the running game's busy to drop.
- TW, 8: width of the tick counters; must hold max(DEBOUNCE_TICKS, CLEAR_TICKS, DRAIN_TIMEOUT).

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- tick, input, 1: one-cycle timebase strobe (1 kHz); all tick counting is gated by it.
- tennis_btn, input, 1: raw, asynchronous tennis select button.
- squash_btn, input, 1: raw, asynchronous squash select button.
- t_busy, input, 1: tennis engine has a rally in progress.
- s_busy, input, 1: squash engine has a rally in progress.
- t_rst_n, output, 1: active-low reset to the tennis engine.
- s_rst_n, output, 1: active-low reset to the squash engine.
- mode, output, 1: 1 = tennis, 0 = squash; drives the output mux.
- disp_en, output, 1: 0 blanks the LED bar and 7-seg at the mux.
- switching, output, 1: high in any non-RUN state.

Behaviour:
- Buttons pass through a 2-FF synchronizer, then a debouncer sampled only on tick.
- The debouncer emits a 1-cycle press pulse on the tick where the count of consecutive high samples reaches DEBOUNCE_TICKS.
- After firing, the debouncer re-arms only after one low sample. Any low sample clears its counter.
- States:
  - RUN: selected game active.
  - DRAIN: waiting for the current game's busy to drop.
  - CLEAR: incoming game held in reset.
- Reset (async): state=RUN, mode=1, t_rst_n=1, s_rst_n=0, disp_en=1, switching=0. All counters and debouncers are cleared.
- RUN:
  - A press for the non-selected game latches pend_mode.
  - If that game's opposite (current) busy=0, go to CLEAR next cycle; otherwise go to DRAIN and clear drain_cnt.
  - A press for the already-selected game is ignored.
- DRAIN:
  - drain_cnt increments on tick.
  - When the current busy is low, go to CLEAR.
  - A press for the current mode cancels the switch and returns to RUN with no reset pulses.
  - The current game stays running and the display stays enabled.
- CLEAR:
  - On entry: mode<=pend_mode and clear_cnt cleared.
  - The outgoing game's rst_n goes 0 immediately. The incoming game's rst_n is held 0.
  - disp_en=0.
  - clear_cnt increments on tick. On the tick where clear_cnt reaches CLEAR_TICKS-1, the incoming rst_n goes 1, disp_en goes 1, and the state returns to RUN.
  - Presses are ignored in CLEAR.
- The inactive game's rst_n is always 0 in RUN.
- Simultaneous tennis and squash presses in the same cycle: tennis wins.
- A busy input of the inactive game is ignored.
- Reset asserted mid-DRAIN or mid-CLEAR returns the block to tennis RUN on the next clock after release; no partial state survives.
- Handover latency with busy=0 at press: 1 cycle to CLEAR, plus CLEAR_TICKS ticks.

Optional Feature:
- Macro GMC_DRAIN_TIMEOUT_EN.
- Defined: in DRAIN, when drain_cnt reaches DRAIN_TIMEOUT on a tick, go to CLEAR regardless of busy, aborting the rally.
- Undefined: DRAIN waits indefinitely for busy to drop; the drain counter is not synthesized.

Decomposition:
- Package gmc_pkg:
  - state enum {RUN, DRAIN, CLEAR}
  - constants MODE_TENNIS=1'b1, MODE_SQUASH=1'b0
- Sub-module gmc_debounce: synchronizer + tick debouncer + single-pulse output. Instantiated twice.

Test Plan:
- Reset release: mode=1, t_rst_n=1, s_rst_n=0, disp_en=1, switching=0.
- squash_btn high 8 ticks with t_busy=0:
  - press pulse on the 8th tick; CLEAR next cycle.
  - t_rst_n=0, disp_en=0 for 4 ticks.
  - Then mode=0, s_rst_n=1, t_rst_n=0, disp_en=1.
- squash_btn high only 5 ticks, then low: no press, no state change.
- t_busy=1 and a squash press: enters DRAIN with disp_en=1. t_busy drops after 20 ticks → CLEAR on the next cycle. A second test presses tennis during DRAIN → back to RUN with t_rst_n never deasserted.
- Both buttons stable 8 ticks in squash mode: tennis selected after CLEAR. Button held continuously afterward: no second press.
- With GMC_DRAIN_TIMEOUT_EN, DRAIN_TIMEOUT=10, t_busy stuck at 1: forced CLEAR on the 10th tick. Without the macro, the block stays in DRAIN for 300 ticks.
